// File: rtl/fpu_norm_shift_if.sv
// Handshake bundle for the mantissa normalizer.
//   in_*  : unnormalized mantissa, leading-one index and exponent, valid/ready
//   out_* : normalized mantissa, adjusted exponent, zero/underflow flags,
//           valid/ready
// master drives the input beat and consumes the result; slave is the shifter.
interface fpu_norm_shift_if #(
    parameter int WIDTH     = 106,
    parameter int WIDTH_LOG = 7,
    parameter int EXP_W     = 11
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_value;
    logic [WIDTH_LOG-1:0] in_msb;
    logic [EXP_W-1:0]     in_exp;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_value;
    logic [EXP_W-1:0]     out_exp;
    logic                 out_zero;
    logic                 out_uflow;

    modport master (
        output in_valid, in_value, in_msb, in_exp, out_ready,
        input  in_ready, out_valid, out_value, out_exp, out_zero, out_uflow
    );

    modport slave (
        input  in_valid, in_value, in_msb, in_exp, out_ready,
        output in_ready, out_valid, out_value, out_exp, out_zero, out_uflow
    );
endinterface

// File: rtl/fpu_norm_shift.sv
// Pipelined left-normalizer for FPU mantissas.
// Takes the leading-one index from the upstream priority encoder, shifts the
// mantissa left so bit WIDTH-1 is set, lowers the exponent by the same amount
// (clamping to 0 and flagging underflow) and flags an all-zero mantissa.
// One barrel-shifter level per register stage, WIDTH_LOG stages in total,
// one result per cycle.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (drops all in-flight beats)
//   bus : fpu_norm_shift_if.slave (input beat, result, valid/ready both sides)
module fpu_norm_shift #(
    parameter int WIDTH     = 106,
    parameter int WIDTH_LOG = 7,
    parameter int EXP_W     = 11
) (
    input  logic               clk,
    input  logic               rst,
    fpu_norm_shift_if.slave    bus
);

    // Stages 0..LAST-1 live in the arrays below; stage LAST is the output register.
    localparam int                   LAST    = WIDTH_LOG - 1;
    localparam logic [WIDTH_LOG-1:0] MAX_IDX = WIDTH_LOG'(WIDTH - 1);

    // Returns {uflow, exponent}: in_exp - shamt, saturated at zero.
    function automatic logic [EXP_W:0] sat_exp(input logic [EXP_W-1:0]     e,
                                               input logic [WIDTH_LOG-1:0] s);
        logic signed [EXP_W:0] diff;
        diff = $signed({1'b0, e}) - $signed({{(EXP_W + 1 - WIDTH_LOG){1'b0}}, s});
        if (diff < 0) sat_exp = {1'b1, {EXP_W{1'b0}}};
        else          sat_exp = {1'b0, diff[EXP_W-1:0]};
    endfunction

    // One barrel level: shift by 2^b when shamt bit b is set.
    function automatic logic [WIDTH-1:0] shift_stage(input logic [WIDTH-1:0]     v,
                                                     input logic [WIDTH_LOG-1:0] s,
                                                     input int                   b);
        shift_stage = s[b] ? (v << (1 << b)) : v;
    endfunction

    logic                 stall;
    logic [WIDTH_LOG-1:0] msb_c;
    logic [WIDTH_LOG-1:0] shamt_c;
    logic                 zero_c;
    logic [EXP_W:0]       sat_c;

    logic [LAST-1:0]      vld_d, vld_q;
    logic [WIDTH-1:0]     val_d   [LAST];
    logic [WIDTH-1:0]     val_q   [LAST];
    logic [WIDTH_LOG-1:0] shamt_d [LAST];
    logic [WIDTH_LOG-1:0] shamt_q [LAST];
    logic [EXP_W-1:0]     exp_d   [LAST];
    logic [EXP_W-1:0]     exp_q   [LAST];
    logic                 zero_d  [LAST];
    logic                 zero_q  [LAST];
    logic                 uflow_d [LAST];
    logic                 uflow_q [LAST];

    logic                 out_valid_d, out_valid_q;
    logic [WIDTH-1:0]     out_value_d, out_value_q;
    logic [EXP_W-1:0]     out_exp_d,   out_exp_q;
    logic                 out_zero_d,  out_zero_q;
    logic                 out_uflow_d, out_uflow_q;

    // A held result freezes the whole pipe, bubbles included.
    assign stall         = out_valid_q & ~bus.out_ready;
    assign bus.in_ready  = ~stall;
    assign bus.out_valid = out_valid_q;
    assign bus.out_value = out_value_q;
    assign bus.out_exp   = out_exp_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.out_uflow = out_uflow_q;

    // Acceptance: shift amount, zero detect and exponent adjust.
    always_comb begin
        msb_c   = (bus.in_msb > MAX_IDX) ? MAX_IDX : bus.in_msb;
        zero_c  = (bus.in_value == '0);
        // in_msb is meaningless for a zero mantissa, so it must not drive the exponent.
        shamt_c = zero_c ? '0 : (MAX_IDX - msb_c);
        sat_c   = sat_exp(bus.in_exp, shamt_c);
    end

    always_comb begin
        // Stage 0: largest shift level, exponent settled here.
        vld_d[0]   = bus.in_valid;
        val_d[0]   = shift_stage(bus.in_value, shamt_c, LAST);
        shamt_d[0] = shamt_c;
        exp_d[0]   = zero_c ? '0 : sat_c[EXP_W-1:0];
        uflow_d[0] = ~zero_c & sat_c[EXP_W];
        zero_d[0]  = zero_c;
        // Stages 1..LAST-1: progressively smaller shift levels.
        for (int k = 1; k < LAST; k++) begin
            vld_d[k]   = vld_q[k-1];
            val_d[k]   = shift_stage(val_q[k-1], shamt_q[k-1], LAST - k);
            shamt_d[k] = shamt_q[k-1];
            exp_d[k]   = exp_q[k-1];
            uflow_d[k] = uflow_q[k-1];
            zero_d[k]  = zero_q[k-1];
        end
        // Stage LAST: shift by one, becomes the visible result.
        out_valid_d = vld_q[LAST-1];
        out_value_d = shift_stage(val_q[LAST-1], shamt_q[LAST-1], 0);
        out_exp_d   = exp_q[LAST-1];
        out_zero_d  = zero_q[LAST-1];
        out_uflow_d = uflow_q[LAST-1];
    end

    // Interior data carries no reset; its valid bit qualifies it.
    always_ff @(posedge clk) begin
        if (!stall) begin
            for (int k = 0; k < LAST; k++) begin
                val_q[k]   <= val_d[k];
                shamt_q[k] <= shamt_d[k];
                exp_q[k]   <= exp_d[k];
                zero_q[k]  <= zero_d[k];
                uflow_q[k] <= uflow_d[k];
            end
        end
    end

    // Valid bits and the visible result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            out_value_q <= '0;
            out_exp_q   <= '0;
            out_zero_q  <= 1'b0;
            out_uflow_q <= 1'b0;
        end else if (!stall) begin
            vld_q       <= vld_d;
            out_valid_q <= out_valid_d;
            out_value_q <= out_value_d;
            out_exp_q   <= out_exp_d;
            out_zero_q  <= out_zero_d;
            out_uflow_q <= out_uflow_d;
        end
    end

endmodule

// File: tb/tb_fpu_norm_shift.sv
// Self-checking bench for fpu_norm_shift: directed beats with literal
// expectations plus a reference model that scores every output cycle.
module tb_fpu_norm_shift;

    localparam int W  = 106;
    localparam int WL = 7;
    localparam int EW = 11;

    typedef struct {
        logic [W-1:0]  v;
        logic [EW-1:0] e;
        logic          z;
        logic          u;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pop    = 0;
    res_t exp_q[$];

    fpu_norm_shift_if #(.WIDTH(W), .WIDTH_LOG(WL), .EXP_W(EW)) bus();

    fpu_norm_shift #(.WIDTH(W), .WIDTH_LOG(WL), .EXP_W(EW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    // Reference: normalize with one plain shift, exponent in signed integers.
    function automatic res_t model(input logic [W-1:0] v, input logic [WL-1:0] msb,
                                   input logic [EW-1:0] e);
        res_t r;
        int   m;
        int   sh;
        int   d;
        if (v == '0) begin
            r.v = '0; r.e = '0; r.z = 1'b1; r.u = 1'b0;
        end else begin
            m   = (int'(msb) > W - 1) ? W - 1 : int'(msb);
            sh  = (W - 1) - m;
            r.v = v << sh;
            r.z = 1'b0;
            d   = int'(e) - sh;
            if (d < 0) begin r.e = '0; r.u = 1'b1; end
            else begin r.e = EW'(d); r.u = 1'b0; end
        end
        return r;
    endfunction

    // Scoreboard: outputs and in_ready checked each cycle, accepted beats queued.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            chk("in_ready_vs_stall", bus.in_ready, !(bus.out_valid && !bus.out_ready));
            if (exp_q.size() == 0) begin
                chk("out_valid_when_nothing_pending", bus.out_valid, 1'b0);
            end else if (bus.out_valid) begin
                chk("sb_out_value", bus.out_value, exp_q[0].v);
                chk("sb_out_exp",   bus.out_exp,   exp_q[0].e);
                chk("sb_out_zero",  bus.out_zero,  exp_q[0].z);
                chk("sb_out_uflow", bus.out_uflow, exp_q[0].u);
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    n_pop++;
                end
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.in_value, bus.in_msb, bus.in_exp));
        end
    end

    // One beat on an idle pipe; result and latency against literal values.
    task automatic send_one(input string nm, input logic [W-1:0] v, input logic [WL-1:0] m,
                            input logic [EW-1:0] e, input logic [W-1:0] xv,
                            input logic [EW-1:0] xe, input logic xz, input logic xu);
        int lat;
        @(posedge clk); #1;
        bus.in_value = v; bus.in_msb = m; bus.in_exp = e; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, lat, 7);
        chk({nm, "_value"},   bus.out_value, xv);
        chk({nm, "_exp"},     bus.out_exp,   xe);
        chk({nm, "_zero"},    bus.out_zero,  xz);
        chk({nm, "_uflow"},   bus.out_uflow, xu);
    endtask

    logic [W-1:0]  s_val [20];
    logic [WL-1:0] s_msb [20];
    logic [EW-1:0] s_exp [20];

    initial begin
        logic [W-1:0] one;
        logic [W-1:0] rnd;
        int           sent;
        int           step;
        int           pop0;
        int           wait_n;
        logic         acc;

        one = 1;
        bus.in_valid = 1'b0; bus.in_value = '0; bus.in_msb = '0; bus.in_exp = '0;
        bus.out_ready = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_value", bus.out_value, '0);
        chk("rst_out_exp",   bus.out_exp,   '0);
        chk("rst_out_zero",  bus.out_zero,  1'b0);
        chk("rst_out_uflow", bus.out_uflow, 1'b0);
        chk("rst_in_ready",  bus.in_ready,  1'b1);

        // Directed single beats.
        send_one("mid",       one << 50, 7'd50, 11'd1000, one << 105, 11'd945, 1'b0, 1'b0);
        send_one("zero",      '0,        7'd17, 11'd500,  '0,         11'd0,   1'b1, 1'b0);
        send_one("uflow",     one,       7'd0,  11'd40,   one << 105, 11'd0,   1'b0, 1'b1);
        send_one("top",       one << 105, 7'd105, 11'd7,  one << 105, 11'd7,   1'b0, 1'b0);
        send_one("exp_to_0",  one << 50, 7'd50, 11'd55,   one << 105, 11'd0,   1'b0, 1'b0);
        send_one("msb_clamp", (one << 105) | 106'd3, 7'd120, 11'd9,
                 (one << 105) | 106'd3, 11'd9, 1'b0, 1'b0);
        send_one("msb_trust", one << 10, 7'd20, 11'd100,  one << 95,  11'd15,  1'b0, 1'b0);
        @(posedge clk); #1;

        // Stream of 20 beats with a 5-cycle output stall in the middle.
        for (int i = 0; i < 20; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            rnd = (i == 7) ? '0 : (rnd >> $urandom_range(0, W - 1));
            s_val[i] = rnd;
            s_msb[i] = '0;
            for (int b = 0; b < W; b++) if (rnd[b]) s_msb[i] = WL'(b);
            s_exp[i] = EW'($urandom_range(0, 2047));
        end
        pop0 = n_pop;
        sent = 0;
        step = 0;
        while (sent < 20 && step < 200) begin
            bus.out_ready = !(step >= 10 && step < 15);
            bus.in_valid  = 1'b1;
            bus.in_value  = s_val[sent];
            bus.in_msb    = s_msb[sent];
            bus.in_exp    = s_exp[sent];
            @(negedge clk);
            acc = bus.in_ready;
            if (step == 12) chk("stream_stall_in_ready", bus.in_ready, 1'b0);
            @(posedge clk); #1;
            if (acc) sent++;
            step++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("stream_all_sent", sent, 20);
        wait_n = 0;
        while (exp_q.size() != 0 && wait_n < 50) begin
            @(posedge clk); #1;
            wait_n++;
        end
        chk("stream_drained", exp_q.size(), 0);
        chk("stream_count",   n_pop - pop0, 20);

        // Reset with 4 beats in flight.
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_value = one << (i + 3);
            bus.in_msb   = WL'(i + 3);
            bus.in_exp   = 11'd200;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("flush_out_valid", bus.out_valid, 1'b0);
            @(posedge clk); #1;
        end
        send_one("after_rst", one << 104, 7'd104, 11'd3, one << 105, 11'd2, 1'b0, 1'b0);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
